// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and one-hot grant codes.
// Grants are {dm,if}; GNT_NONE marks an idle port.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_DM   = 2'b10;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the requester
// that did not win last time is chosen. Purely combinational, no backpressure.
module arb_rr_pick
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        unique case (req_i)
            2'b01:   gnt_o = GNT_IF;
            2'b10:   gnt_o = GNT_DM;
            2'b11:   gnt_o = (last_i == GNT_IF) ? GNT_DM : GNT_IF;
            default: gnt_o = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters, one transaction at a time.
// Latency 2+MEM_LAT cycles from req to done; requesters hold req until their done pulse.
module mem_port_arbiter
    import riscv_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    arb_state_t        state_q;
    logic [1:0]        last_q;
    logic [1:0]        grant_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_done_q;
    logic              dm_done_q;

    logic [1:0]        pick_gnt;
    logic              pick_dm;

    arb_rr_pick u_pick (
        .req_i  ({dm_req, if_req}),
        .last_i (last_q),
        .gnt_o  (pick_gnt)
    );

    assign pick_dm = (pick_gnt == GNT_DM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= GNT_DM;
            grant_q     <= GNT_NONE;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            mem_wr_q  <= 1'b0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Request fields are latched here; later changes on the inputs are ignored.
                    if (pick_gnt != GNT_NONE) begin
                        state_q     <= ISSUE;
                        grant_q     <= pick_gnt;
                        last_q      <= pick_gnt;
                        busy_q      <= 1'b1;
                        mem_addr_q  <= pick_dm ? dm_addr : if_addr;
                        mem_wdata_q <= pick_dm ? dm_wdata : '0;
                        we_q        <= pick_dm && dm_we;
                        mem_wr_q    <= pick_dm && dm_we;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= CNT_W'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (grant_q == GNT_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_done_q  <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    grant_q <= GNT_NONE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_done   = dm_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_wr_only_issue: assert property (@(posedge clk) disable iff (rst) mem_wr_q |-> (state_q == ISSUE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Instance with MEM_LAT=1
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_done, dm_done, mem_wr, busy;
    logic [1:0]  grant;

    // Instance with MEM_LAT=3
    logic        if_req3 = 1'b0, dm_req3 = 1'b0, dm_we3 = 1'b0;
    logic [31:0] if_addr3 = '0, dm_addr3 = '0, dm_wdata3 = '0;
    logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        if_done3, dm_done3, mem_wr3, busy3;
    logic [1:0]  grant3;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_done(if_done3),
        .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
        .dm_rdata(dm_rdata3), .dm_done(dm_done3),
        .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .grant(grant3), .busy(busy3)
    );

    // Memory models with preload port
    logic        pl_en = 1'b0, pl_sel = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] pipe3_0, pipe3_1, pipe3_2;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem1[pl_idx] <= pl_dat;
        else if (mem_wr)      mem1[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem1[mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (pl_en && pl_sel) mem3[pl_idx] <= pl_dat;
        else if (mem_wr3)    mem3[mem_addr3[9:2]] <= mem_wdata3;
        pipe3_0 <= mem3[mem_addr3[9:2]];
        pipe3_1 <= pipe3_0;
        pipe3_2 <= pipe3_1;
    end
    assign mem_rdata3 = pipe3_2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    always @(negedge clk) if (mem_wr) wr_cnt <= wr_cnt + 1;

    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    logic [31:0] dm3_q[$];
    int          order_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Scoreboard monitor: pops expectations whenever a done pulse appears
    always @(negedge clk) begin
        if (if_done && dm_done) fail("both_done");
        if (if_done) begin
            chk("if_done_grant", 32'(grant), 32'(2'b01));
            if (if_q.size() == 0) fail("if_done_unexpected");
            else chk("if_rdata", if_rdata, if_q.pop_front());
            if (order_q.size() == 0) fail("if_order_unexpected");
            else chk("grant_order", 32'd1, 32'(order_q.pop_front()));
        end
        if (dm_done) begin
            chk("dm_done_grant", 32'(grant), 32'(2'b10));
            if (dm_q.size() == 0) fail("dm_done_unexpected");
            else chk("dm_rdata", dm_rdata, dm_q.pop_front());
            if (order_q.size() == 0) fail("dm_order_unexpected");
            else chk("grant_order", 32'd2, 32'(order_q.pop_front()));
        end
        if (if_done3) chk("lat3_if_done_unexpected", if_rdata3, 32'hFFFF_FFFF);
        if (dm_done3) begin
            chk("lat3_dm_done_grant", 32'(grant3), 32'(2'b10));
            if (dm3_q.size() == 0) fail("lat3_dm_done_unexpected");
            else chk("lat3_dm_rdata", dm_rdata3, dm3_q.pop_front());
        end
    end

    task automatic preload(input logic sel, input logic [31:0] addr, input logic [31:0] dat);
        pl_en = 1'b1; pl_sel = sel; pl_idx = addr[9:2]; pl_dat = dat;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Called #1 after a posedge; exp_lat < 0 skips the latency check (contention)
    task automatic if_xact(input logic [31:0] addr, input logic [31:0] exp_rd, input int exp_lat);
        int t0;
        int n;
        if_q.push_back(exp_rd);
        if_addr = addr; if_req = 1'b1; t0 = cyc; n = 0;
        do begin @(negedge clk); n++; end while (!if_done && n < 100);
        if (!if_done) fail("if_timeout");
        else if (exp_lat >= 0) chk("if_latency", 32'(cyc - t0), 32'(exp_lat));
        @(posedge clk); #1 if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic dm_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input int exp_lat);
        int t0;
        int n;
        dm_q.push_back(exp_rd);
        dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1; t0 = cyc; n = 0;
        do begin @(negedge clk); n++; end while (!dm_done && n < 100);
        if (!dm_done) fail("dm_timeout");
        else if (exp_lat >= 0) chk("dm_latency", 32'(cyc - t0), 32'(exp_lat));
        @(posedge clk); #1 dm_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int w0;
        int t0;
        int n;

        preload(1'b0, 32'h0,   32'h00A0_0093);
        preload(1'b0, 32'h100, 32'h1111_1111);
        preload(1'b0, 32'h104, 32'h2222_2222);
        preload(1'b0, 32'h108, 32'h3333_3333);
        preload(1'b0, 32'h10C, 32'h4444_4444);
        preload(1'b1, 32'h20,  32'h1234_5678);
        preload(1'b1, 32'h24,  32'hBADB_AD00);

        @(negedge clk);
        chk("rst_grant",    32'(grant), 32'h0);
        chk("rst_busy",     32'(busy), 32'h0);
        chk("rst_mem_wr",   32'(mem_wr), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_dones",    32'({if_done, dm_done}), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: first fetch, IF only
        order_q.push_back(1);
        fork
            if_xact(32'h0, 32'h00A0_0093, 3);
            begin
                @(negedge clk); chk("t1_grant_idle", 32'(grant), 32'h0);
                @(negedge clk); chk("t1_grant_issue", 32'(grant), 32'h1);
                                chk("t1_busy_issue", 32'(busy), 32'h1);
                                chk("t1_mem_addr", mem_addr, 32'h0);
                @(negedge clk); chk("t1_grant_wait", 32'(grant), 32'h1);
            end
        join

        // 2: store, load back, second store leaves dm_rdata alone
        order_q.push_back(2);
        w0 = wr_cnt;
        dm_xact(1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 3);
        chk("t2_store_wr_cycles", 32'(wr_cnt - w0), 32'd1);
        order_q.push_back(2);
        w0 = wr_cnt;
        dm_xact(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 3);
        chk("t2_load_wr_cycles", 32'(wr_cnt - w0), 32'd0);
        order_q.push_back(2);
        dm_xact(1'b1, 32'h44, 32'hCAFE_F00D, 32'hDEAD_BEEF, 3);

        // 3: both pending, IF wins the tie (last=DM), then alternation
        order_q.push_back(1); order_q.push_back(2);
        order_q.push_back(1); order_q.push_back(2);
        fork
            begin
                if_xact(32'h100, 32'h1111_1111, -1);
                if_xact(32'h108, 32'h3333_3333, -1);
            end
            begin
                dm_xact(1'b0, 32'h104, 32'h0, 32'h2222_2222, -1);
                dm_xact(1'b0, 32'h10C, 32'h0, 32'h4444_4444, -1);
            end
        join

        // 3b: after an IF grant, a tie goes to DM
        order_q.push_back(1);
        if_xact(32'h0, 32'h00A0_0093, 3);
        order_q.push_back(2); order_q.push_back(1);
        fork
            if_xact(32'h100, 32'h1111_1111, -1);
            dm_xact(1'b0, 32'h104, 32'h0, 32'h2222_2222, -1);
        join

        // 6: dm_req dropped during ISSUE still completes
        order_q.push_back(2);
        dm_q.push_back(32'hDEAD_BEEF);
        dm_we = 1'b0; dm_addr = 32'h40; dm_req = 1'b1; t0 = cyc;
        @(posedge clk); #1 dm_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dm_done && n < 100);
        if (!dm_done) fail("t6_timeout");
        else chk("t6_latency", 32'(cyc - t0), 32'd3);
        @(negedge clk);
        chk("t6_idle_busy", 32'(busy), 32'h0);
        chk("t6_idle_grant", 32'(grant), 32'h0);
        @(posedge clk); #1;

        // 4: reset during WAIT of a store
        dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h55AA_55AA; dm_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t4_wait_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("t4_mem_wr", 32'(mem_wr), 32'h0);
        chk("t4_grant", 32'(grant), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_dm_done", 32'(dm_done), 32'h0);
        chk("t4_if_rdata_clr", if_rdata, 32'h0);
        chk("t4_dm_rdata_clr", dm_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // 5: MEM_LAT=3 load, address changed during WAIT
        dm3_q.push_back(32'h1234_5678);
        dm_we3 = 1'b0; dm_addr3 = 32'h20; dm_req3 = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1 dm_addr3 = 32'h24;
        @(negedge clk);
        chk("t5_mem_addr_latched", mem_addr3, 32'h20);
        chk("t5_busy", 32'(busy3), 32'h1);
        n = 0;
        while (!dm_done3 && n < 100) begin @(negedge clk); n++; end
        if (!dm_done3) fail("t5_timeout");
        else chk("t5_latency", 32'(cyc - t0), 32'd5);
        @(posedge clk); #1 dm_req3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("if_q_drained",    32'(if_q.size()), 32'd0);
        chk("dm_q_drained",    32'(dm_q.size()), 32'd0);
        chk("dm3_q_drained",   32'(dm3_q.size()), 32'd0);
        chk("order_q_drained", 32'(order_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
